// File: rtl/debounce_filter.sv
// debounce_filter: glitch filter and edge detector for an already-synchronized
// level. The output follows the input only after STABLE_CYCLES consecutive
// qualified samples disagree with it; rise/fall pulse for one clock on each
// accepted change.
module debounce_filter #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        INIT          = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  input  logic sample_en,
  output logic level,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_WAIT   = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Qualification FSM; pulses clear every clock, state moves only on sample_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_STABLE;
      cnt   <= '0;
      level <= INIT;
      rise  <= 1'b0;
      fall  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sample_en) begin
        case (state)
          ST_STABLE: begin
            if (in == level) begin
              cnt <= '0;
            end else if (STABLE_CYCLES == 1) begin
              level <= in;
              rise  <= in;
              fall  <= ~in;
              cnt   <= '0;
            end else begin
              cnt   <= CNT_ONE;
              state <= ST_WAIT;
              busy  <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (in == level) begin
              cnt   <= '0;
              state <= ST_STABLE;
              busy  <= 1'b0;
            end else if (cnt == CNT_LAST) begin
              level <= ~level;
              rise  <= ~level;
              fall  <= level;
              cnt   <= '0;
              state <= ST_STABLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: begin
            cnt   <= '0;
            state <= ST_STABLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
